din_debouncer: RTL and testbench

Cleans a raw asynchronous input, such as a switch or external pin, into a glitch-free, clock-synchronous level. It also produces single-cycle rise and fall pulses. It sits directly downstream of the d_ff input-capture flops: its synchronizer is a chain of d_ff-style stages, and its `q` output feeds the control logic.

---
 rtl/debounce_pkg.sv | 32 +++
 rtl/sync_chain.sv | 36 +++
 rtl/din_debouncer.sv | 148 ++++++++++++++
 tb/tb_din_debouncer.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared types and defaults for the din_debouncer block.
package debounce_pkg;

    // Debouncer FSM states: two settled levels and two qualification states.
    typedef enum logic [1:0] {
        StLow       = 2'd0,
        StCheckHigh = 2'd1,
        StHigh      = 2'd2,
        StCheckLow  = 2'd3
    } deb_state_e;

    // Ceiling log2, used to size counters from a maximum count value.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned v;
        res = 0;
        if (value > 1) begin
            v = value - 1;
            while (v > 0) begin
                res = res + 1;
                v   = v >> 1;
            end
        end
        return res;
    endfunction

    localparam int unsigned DefaultSyncStages   = 2;
    localparam int unsigned DefaultStableCycles = 8;
    // Counter must hold values up to DefaultStableCycles.
    localparam int unsigned DefaultCntW         = clog2(DefaultStableCycles + 1);

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous bit.
module sync_chain
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DefaultSyncStages
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d,
    output logic q
);

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("sync_chain: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] stage_q;
    logic [SYNC_STAGES-1:0] stage_d;

    // Shift the raw input one stage deeper every cycle.
    always_comb begin
        stage_d = {stage_q[SYNC_STAGES-2:0], d};
    end

    // Plain d_ff stages with asynchronous clear.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[SYNC_STAGES-1];

endmodule

// File: rtl/din_debouncer.sv
// Debouncer: synchronizes din, qualifies each level change over an unbroken
// run of equal samples, and emits registered level, edge pulses and busy.
module din_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES   = DefaultSyncStages,
    parameter int unsigned STABLE_CYCLES = DefaultStableCycles,
    parameter int unsigned CNT_W         = DefaultCntW
) (
    input  logic clk,
    input  logic n_rst,
    input  logic din,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("din_debouncer: SYNC_STAGES must be at least 2");
    end
    if (STABLE_CYCLES < 1) begin : g_bad_stable
        $error("din_debouncer: STABLE_CYCLES must be at least 1");
    end
    if (longint'(STABLE_CYCLES) > (longint'(1) << CNT_W) - 1) begin : g_bad_cnt_w
        $error("din_debouncer: CNT_W too small for STABLE_CYCLES");
    end

    localparam logic [CNT_W-1:0] StableCnt = CNT_W'(STABLE_CYCLES);
    // With a single-sample requirement the CHECK states are skipped.
    localparam bit Direct = (STABLE_CYCLES == 1);

    logic             s;
    deb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             q_q, q_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             busy_q, busy_d;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .n_rst(n_rst),
        .d    (din),
        .q    (s)
    );

    // cnt_q stays below STABLE_CYCLES, so the increment cannot wrap.
    assign cnt_inc = cnt_q + 1'b1;

    // Next-state, counter and output decode for the qualification FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        q_d     = q_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            StLow: begin
                if (s) begin
                    if (Direct) begin
                        state_d = StHigh;
                        cnt_d   = '0;
                        q_d     = 1'b1;
                        rise_d  = 1'b1;
                    end else begin
                        state_d = StCheckHigh;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            StCheckHigh: begin
                if (!s) begin
                    // Opposite sample: drop the candidate entirely.
                    state_d = StLow;
                    cnt_d   = '0;
                end else if (cnt_inc == StableCnt) begin
                    state_d = StHigh;
                    cnt_d   = '0;
                    q_d     = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StHigh: begin
                if (!s) begin
                    if (Direct) begin
                        state_d = StLow;
                        cnt_d   = '0;
                        q_d     = 1'b0;
                        fall_d  = 1'b1;
                    end else begin
                        state_d = StCheckLow;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end
            StCheckLow: begin
                if (s) begin
                    state_d = StHigh;
                    cnt_d   = '0;
                end else if (cnt_inc == StableCnt) begin
                    state_d = StLow;
                    cnt_d   = '0;
                    q_d     = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = StLow;
                cnt_d   = '0;
                q_d     = 1'b0;
            end
        endcase
        busy_d = (state_d == StCheckHigh) || (state_d == StCheckLow);
    end

    // State, counter and all outputs registered together.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= StLow;
            cnt_q   <= '0;
            q_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    assign q    = q_q;
    assign rise = rise_q;
    assign fall = fall_q;
    assign busy = busy_q;

endmodule

// File: tb/tb_din_debouncer.sv
// Bench for din_debouncer: default instance plus a STABLE_CYCLES=1 instance,
// both compared every cycle against a run-length reference model.
module tb_din_debouncer;

    localparam int unsigned Sync = 2;

    logic clk   = 1'b0;
    logic n_rst = 1'b1;
    logic din   = 1'b0;
    logic q0, rise0, fall0, busy0;
    logic q1, rise1, fall1, busy1;

    int checks = 0;
    int errors = 0;

    always #10 clk = ~clk;

    din_debouncer #(
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(8),
        .CNT_W        (4)
    ) u_dut (
        .clk  (clk),
        .n_rst(n_rst),
        .din  (din),
        .q    (q0),
        .rise (rise0),
        .fall (fall0),
        .busy (busy0)
    );

    din_debouncer #(
        .SYNC_STAGES  (2),
        .STABLE_CYCLES(1),
        .CNT_W        (4)
    ) u_dut_fast (
        .clk  (clk),
        .n_rst(n_rst),
        .din  (din),
        .q    (q1),
        .rise (rise1),
        .fall (fall1),
        .busy (busy1)
    );

    function automatic int unsigned stable_of(input int i);
        return (i == 0) ? 8 : 1;
    endfunction

    // Reference model: q flips once the synchronized input has disagreed with
    // q for stable_of(i) consecutive samples; any agreeing sample resets the run.
    bit          dly[$];
    int unsigned run[2];
    bit          mq[2], mrise[2], mfall[2], mbusy[2];

    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dly = {};
            for (int k = 0; k < Sync; k++) dly.push_back(1'b0);
            for (int i = 0; i < 2; i++) begin
                run[i] = 0; mq[i] = 0; mrise[i] = 0; mfall[i] = 0; mbusy[i] = 0;
            end
        end else begin
            bit s;
            s = dly.pop_front();
            dly.push_back(din);
            for (int i = 0; i < 2; i++) begin
                mrise[i] = 0;
                mfall[i] = 0;
                if (s != mq[i]) begin
                    run[i]++;
                    if (run[i] >= stable_of(i)) begin
                        mq[i]    = s;
                        mrise[i] = s;
                        mfall[i] = !s;
                        run[i]   = 0;
                    end
                end else begin
                    run[i] = 0;
                end
                mbusy[i] = (run[i] != 0);
            end
        end
    end

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_q0"}, q0, 1'b0);
        check({tag, "_rise0"}, rise0, 1'b0);
        check({tag, "_fall0"}, fall0, 1'b0);
        check({tag, "_busy0"}, busy0, 1'b0);
        check({tag, "_q1"}, q1, 1'b0);
    endtask

    // One clock edge, then compare both instances against the model.
    task automatic cycle();
        @(posedge clk);
        #1;
        check("q0", q0, mq[0]);
        check("rise0", rise0, mrise[0]);
        check("fall0", fall0, mfall[0]);
        check("busy0", busy0, mbusy[0]);
        check("q1", q1, mq[1]);
        check("rise1", rise1, mrise[1]);
        check("fall1", fall1, mfall[1]);
        check("busy1", busy1, mbusy[1]);
    endtask

    task automatic set_din(input logic v);
        @(negedge clk);
        din = v;
    endtask

    // Run 30 edges; report the first edge where q equals want (-1 if never)
    // and pulse/busy counts for the default instance.
    task automatic measure(input logic want, output int lat0, output int lat1,
                           output int r0, output int f0, output int b0);
        lat0 = -1; lat1 = -1; r0 = 0; f0 = 0; b0 = 0;
        for (int k = 1; k <= 30; k++) begin
            cycle();
            if (lat0 < 0 && q0 === want) lat0 = k;
            if (lat1 < 0 && q1 === want) lat1 = k;
            r0 = r0 + int'(rise0);
            f0 = f0 + int'(fall0);
            b0 = b0 + int'(busy0);
        end
    endtask

    initial begin
        int lat0, lat1, r0, f0, b0;

        // Reset held while din toggles asynchronously.
        #1 n_rst = 1'b0;
        #1;
        check_zero("rst_assert");
        for (int k = 0; k < 14; k++) begin
            #7 din = ~din;
            check_zero("rst_hold");
        end
        din = 1'b0;
        @(negedge clk);
        n_rst = 1'b1;
        repeat (3) cycle();

        // Clean rise.
        set_din(1'b1);
        measure(1'b1, lat0, lat1, r0, f0, b0);
        check_int("rise_latency", lat0, 10);
        check_int("rise_latency_fast", lat1, 3);
        check_int("rise_pulses", r0, 1);
        check_int("rise_fall_pulses", f0, 0);
        check_int("rise_busy_cycles", b0, 7);

        // Clean fall.
        set_din(1'b0);
        measure(1'b0, lat0, lat1, r0, f0, b0);
        check_int("fall_latency", lat0, 10);
        check_int("fall_pulses", f0, 1);
        check_int("fall_rise_pulses", r0, 0);

        // Glitch of 5 cycles is rejected.
        set_din(1'b1);
        repeat (5) cycle();
        set_din(1'b0);
        measure(1'b1, lat0, lat1, r0, f0, b0);
        check_int("glitch_latency", lat0, -1);
        check_int("glitch_rise_pulses", r0, 0);
        check("glitch_busy_end", busy0, 1'b0);

        // Interrupted qualification restarts from the second capture.
        set_din(1'b1);
        repeat (4) cycle();
        set_din(1'b0);
        cycle();
        set_din(1'b1);
        measure(1'b1, lat0, lat1, r0, f0, b0);
        check_int("interrupt_latency", lat0, 10);
        check_int("interrupt_rise_pulses", r0, 1);

        // Reset in the middle of a rising qualification.
        set_din(1'b0);
        repeat (30) cycle();
        set_din(1'b1);
        repeat (7) cycle();
        check("midcheck_busy", busy0, 1'b1);
        #4 n_rst = 1'b0;
        #1;
        check_zero("midcheck_rst");
        repeat (2) cycle();
        @(negedge clk);
        n_rst = 1'b1;
        measure(1'b1, lat0, lat1, r0, f0, b0);
        check_int("post_rst_latency", lat0, 10);
        check_int("post_rst_latency_fast", lat1, 3);
        check_int("post_rst_rise_pulses", r0, 1);

        // Random segments with occasional mid-cycle resets.
        for (int seg = 0; seg < 150; seg++) begin
            int len;
            if ($urandom_range(0, 19) == 0) begin
                cycle();
                #4 n_rst = 1'b0;
                #1;
                check_zero("rand_rst");
                @(negedge clk);
                n_rst = 1'b1;
            end
            set_din(1'($urandom_range(0, 1)));
            len = $urandom_range(1, 12);
            repeat (len) cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
